pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit for the processor core.
- Tracks in-flight destination registers across DEPTH post-decode stages.
- Generates per-operand forwarding selects, load-use stalls and redirect flushes.
- Runs a halt drain state machine with cycle/retire/stall/flush counters, replacing the ad-hoc forwarding muxes and halt counter in the top level.

Parameters:
- AW, 5, register address width (register 0 hard-wired zero, never forwarded or stalled on)
- DEPTH, 2, tracked stages after decode (slot 1 = execute … slot DEPTH = writeback); legal 1..6
- LOAD_LAT, 1, extra cycles before a load result is forwardable; legal 0..DEPTH-1
- CW, 32, counter width
- SW, $clog2(DEPTH+1), forward-select width

Ports:
- sysclk  in  1  clock
- cpu_resetn  in  1  asynchronous active-low reset
- issue_valid  in  1  decode holds a real instruction
- issue_dst  in  AW  destination register of decode instruction (0 = none)
- issue_is_load  in  1  decode instruction is a load
- issue_halt  in  1  decode instruction is the halt opcode
- rs_d  in  AW  decode source s
- rt_d  in  AW  decode source t
- redirect  in  1  instruction in slot 1 takes a branch/jump
- stall_d  out  1  hold PC and fetch/decode register; bubble into slot 1
- flush_fd  out  1  kill fetch/decode register contents
- fwd_s_sel  out  SW  0 = register file, k = result of slot k
- fwd_t_sel  out  SW  as above for rt_d
- halted  out  1  halt drained
- cycle_count  out  CW  cycles since reset until halted
- retire_count  out  CW  instructions leaving slot DEPTH
- stall_count  out  CW  cycles with stall_d=1 in RUN
- flush_count  out  CW  cycles with redirect=1

Behaviour:
- Reset (asynchronous, cpu_resetn=0):
  - all slots invalid; state RUN
  - all outputs 0, all counters 0
- Slot entry: {valid, dst, is_load, age}. Every cycle slots shift k→k+1; slot DEPTH drops out.
- Slot 1 load:
  - accepted decode instruction when issue_valid & !stall_d & !redirect & state==RUN
  - otherwise a bubble (valid=0)
- Result ready in slot k: non-load if k≥1; load if k≥1+LOAD_LAT.
- Forward select (combinational):
  - smallest k with valid & dst==src & src!=0, else 0.
  - If that slot is not ready: stall_d=1, select value don't-care.
  - A younger match always shadows an older one.
- Stall: stall_d = (s-hazard | t-hazard) & issue_valid & state==RUN, or state==DRAIN.
- Redirect priority:
  - redirect=1 forces flush_fd=1 and stall_d=0; the decode instruction is discarded (not placed in slot 1).
  - Redirect beats stall in the same cycle.
- Halt FSM:
  - RUN→DRAIN when a halt instruction is accepted into slot 1. A flushed halt is ignored.
  - DRAIN→HALTED when all slots are invalid. A redirect in DRAIN is counted but causes no state change.
  - HALTED is absorbing until reset.
  - halted=1 only in HALTED (registered; rises the cycle after slots are empty).
- Counters:
  - cycle_count +1 every cycle in RUN/DRAIN
  - retire_count +1 when slot DEPTH is valid at the clock edge
  - stall_count +1 when stall_d=1 and state==RUN
  - flush_count +1 on redirect
  - All saturate at 2^CW-1; all freeze in HALTED.
- Reset mid-operation: returns immediately to the reset state; no drain.

Decomposition:
- Shared package cpu_pkg:
  - OP_HALT=6'b111111
  - state enum {RUN, DRAIN, HALTED}
  - slot struct {valid, dst, is_load}
- One natural sub-module, sat_counter (CW, inc, freeze). Instantiate four times.

Test Plan:
- DEPTH=2, LOAD_LAT=0. Issue add r9←…; next cycle issue rs_d=9 → fwd_s_sel=1, stall_d=0; a cycle later a consumer gets fwd_s_sel=2; after that fwd_s_sel=0.
- LOAD_LAT=1. Load r4, then immediately rt_d=4 → stall_d=1 for 1 cycle, stall_count=1, then fwd_t_sel=2, retire_count increments by 2 after both leave.
- Two in-flight writers to r7 (slot 1 and slot 2), consumer rs_d=7 → fwd_s_sel=1. rs_d=0 with slot dst 0 → fwd_s_sel=0, no stall.
- Redirect=1 while the decode instruction has a load-use hazard → flush_fd=1, stall_d=0, slot 1 bubble next cycle, flush_count=1.
- Issue halt after 3 instructions (DEPTH=2) → stall_d=1 in DRAIN; halted=1 exactly 3 cycles after halt accepted; retire_count=4; cycle_count frozen for 10 further cycles.
- Assert cpu_resetn=0 during DRAIN → all outputs 0 asynchronously; after release state RUN, a fresh issue is accepted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline control slice.
//   OP_HALT : halt opcode encoding used by the decoder
//   state_e : halt drain state machine states
//   slot_t  : one tracked post-decode pipeline slot
package cpu_pkg;

  localparam logic [5:0] OP_HALT = 6'b111111;

  // Widest register address a tracked slot can hold; narrower AW zero-extends.
  localparam int unsigned SLOT_AW = 8;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] dst;
    logic               is_load;
  } slot_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a freeze input.
//   sysclk     : clock
//   cpu_resetn : asynchronous active-low reset, clears the count
//   inc        : add one this cycle (ignored at all-ones)
//   freeze     : hold the count regardless of inc
//   count      : current value
module sat_counter #(
  parameter int unsigned CW = 32
) (
  input  logic          sysclk,
  input  logic          cpu_resetn,
  input  logic          inc,
  input  logic          freeze,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !freeze && (count_q != {CW{1'b1}})) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: tracks in-flight destinations over DEPTH post-decode
// slots, produces operand forwarding selects, load-use stalls, redirect
// flushes, and drains the pipe on halt while keeping performance counters.
//   sysclk, cpu_resetn         : clock, asynchronous active-low reset
//   issue_valid/dst/is_load/halt : instruction currently in decode
//   rs_d, rt_d                 : decode source registers
//   redirect                   : slot-1 instruction takes a branch/jump
//   stall_d                    : hold PC and fetch/decode, bubble into slot 1
//   flush_fd                   : kill fetch/decode register
//   fwd_s_sel, fwd_t_sel       : 0 = register file, k = result of slot k
//   halted                     : halt fully drained
//   cycle/retire/stall/flush_count : saturating counters, frozen once halted
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned AW       = 5,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CW       = 32,
  parameter int unsigned SW       = $clog2(DEPTH + 1)
) (
  input  logic          sysclk,
  input  logic          cpu_resetn,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_dst,
  input  logic          issue_is_load,
  input  logic          issue_halt,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic          redirect,
  output logic          stall_d,
  output logic          flush_fd,
  output logic [SW-1:0] fwd_s_sel,
  output logic [SW-1:0] fwd_t_sel,
  output logic          halted,
  output logic [CW-1:0] cycle_count,
  output logic [CW-1:0] retire_count,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  if (DEPTH < 1 || DEPTH > 6) begin : g_bad_depth
    $error("pipe_ctrl: DEPTH must be in 1..6");
  end
  if (LOAD_LAT > DEPTH - 1) begin : g_bad_load_lat
    $error("pipe_ctrl: LOAD_LAT must be in 0..DEPTH-1");
  end
  if (AW > SLOT_AW) begin : g_bad_aw
    $error("pipe_ctrl: AW exceeds slot address width");
  end

  // Index i holds slot i+1 (index 0 = execute).
  slot_t  slot_q [DEPTH];
  slot_t  slot_d [DEPTH];
  state_e state_q, state_d;

  logic haz_s, haz_t, any_valid, in_run, in_drain, accept;

  assign in_run   = (state_q == RUN);
  assign in_drain = (state_q == DRAIN);

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    fwd_s_sel = '0;
    fwd_t_sel = '0;
    haz_s     = 1'b0;
    haz_t     = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (slot_q[i].valid && (rs_d != '0) && (slot_q[i].dst == SLOT_AW'(rs_d))) begin
        fwd_s_sel = SW'(i + 1);
        haz_s     = slot_q[i].is_load && (i < int'(LOAD_LAT));
      end
      if (slot_q[i].valid && (rt_d != '0) && (slot_q[i].dst == SLOT_AW'(rt_d))) begin
        fwd_t_sel = SW'(i + 1);
        haz_t     = slot_q[i].is_load && (i < int'(LOAD_LAT));
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      any_valid = any_valid | slot_q[i].valid;
    end
  end

  // Redirect wins over any stall: the decode instruction is dropped anyway.
  assign flush_fd = redirect;
  assign stall_d  = !redirect && ((((haz_s | haz_t) && issue_valid && in_run)) || in_drain);
  assign accept   = issue_valid && in_run && !stall_d && !redirect;

  always_comb begin
    slot_d[0] = '0;
    if (accept) begin
      slot_d[0].valid   = 1'b1;
      slot_d[0].dst     = SLOT_AW'(issue_dst);
      slot_d[0].is_load = issue_is_load;
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      slot_d[i] = slot_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && issue_halt) state_d = DRAIN;
      DRAIN:   if (!any_valid) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      slot_q  <= '{default: '0};
      state_q <= RUN;
    end else begin
      slot_q  <= slot_d;
      state_q <= state_d;
    end
  end

  assign halted = (state_q == HALTED);

  sat_counter #(.CW(CW)) u_cycle_cnt (
    .sysclk     (sysclk),
    .cpu_resetn (cpu_resetn),
    .inc        (1'b1),
    .freeze     (halted),
    .count      (cycle_count)
  );

  sat_counter #(.CW(CW)) u_retire_cnt (
    .sysclk     (sysclk),
    .cpu_resetn (cpu_resetn),
    .inc        (slot_q[DEPTH-1].valid),
    .freeze     (halted),
    .count      (retire_count)
  );

  sat_counter #(.CW(CW)) u_stall_cnt (
    .sysclk     (sysclk),
    .cpu_resetn (cpu_resetn),
    .inc        (stall_d && in_run),
    .freeze     (halted),
    .count      (stall_count)
  );

  sat_counter #(.CW(CW)) u_flush_cnt (
    .sysclk     (sysclk),
    .cpu_resetn (cpu_resetn),
    .inc        (redirect),
    .freeze     (halted),
    .count      (flush_count)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (DEPTH=2, LOAD_LAT=1) plus a 3-bit-counter
// instance sharing the same stimulus to observe saturation.
module tb_pipe_ctrl;

  logic       sysclk;
  logic       cpu_resetn;
  logic       issue_valid;
  logic [4:0] issue_dst;
  logic       issue_is_load;
  logic       issue_halt;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic       redirect;

  logic        stall_d, flush_fd, halted;
  logic [1:0]  fwd_s_sel, fwd_t_sel;
  logic [31:0] cycle_count, retire_count, stall_count, flush_count;

  logic        stall_d_s, flush_fd_s, halted_s;
  logic [1:0]  fwd_s_sel_s, fwd_t_sel_s;
  logic [2:0]  cycle_count_s, retire_count_s, stall_count_s, flush_count_s;

  int checks = 0;
  int failures = 0;
  int exp_cycles = 0;
  bit exp_halted = 1'b0;

  pipe_ctrl #(.AW(5), .DEPTH(2), .LOAD_LAT(1), .CW(32), .SW(2)) dut (
    .sysclk        (sysclk),
    .cpu_resetn    (cpu_resetn),
    .issue_valid   (issue_valid),
    .issue_dst     (issue_dst),
    .issue_is_load (issue_is_load),
    .issue_halt    (issue_halt),
    .rs_d          (rs_d),
    .rt_d          (rt_d),
    .redirect      (redirect),
    .stall_d       (stall_d),
    .flush_fd      (flush_fd),
    .fwd_s_sel     (fwd_s_sel),
    .fwd_t_sel     (fwd_t_sel),
    .halted        (halted),
    .cycle_count   (cycle_count),
    .retire_count  (retire_count),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  pipe_ctrl #(.AW(5), .DEPTH(2), .LOAD_LAT(1), .CW(3), .SW(2)) dut_sat (
    .sysclk        (sysclk),
    .cpu_resetn    (cpu_resetn),
    .issue_valid   (issue_valid),
    .issue_dst     (issue_dst),
    .issue_is_load (issue_is_load),
    .issue_halt    (issue_halt),
    .rs_d          (rs_d),
    .rt_d          (rt_d),
    .redirect      (redirect),
    .stall_d       (stall_d_s),
    .flush_fd      (flush_fd_s),
    .fwd_s_sel     (fwd_s_sel_s),
    .fwd_t_sel     (fwd_t_sel_s),
    .halted        (halted_s),
    .cycle_count   (cycle_count_s),
    .retire_count  (retire_count_s),
    .stall_count   (stall_count_s),
    .flush_count   (flush_count_s)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Inputs change 1 time unit after the active edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge sysclk);
    #1;
    if (!exp_halted) exp_cycles++;
  endtask

  task automatic drive(input logic v, input logic [4:0] dst, input logic ld, input logic hlt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic rd);
    issue_valid   = v;
    issue_dst     = dst;
    issue_is_load = ld;
    issue_halt    = hlt;
    rs_d          = rs;
    rt_d          = rt;
    redirect      = rd;
    #1;
  endtask

  initial begin
    cpu_resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_stall", 32'(stall_d), 0);
    chk("rst_flush", 32'(flush_fd), 0);
    chk("rst_fwd_s", 32'(fwd_s_sel), 0);
    chk("rst_fwd_t", 32'(fwd_t_sel), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_cycle", cycle_count, 0);
    chk("rst_retire", retire_count, 0);
    #9;
    cpu_resetn = 1'b1;

    // Non-load producer r9 forwarded from slot 1, then slot 2, then regfile.
    drive(1, 9, 0, 0, 0, 0, 0);
    chk("t1_stall0", 32'(stall_d), 0);
    tick();
    drive(1, 10, 0, 0, 9, 0, 0);
    chk("t1_fwd_s1", 32'(fwd_s_sel), 1);
    chk("t1_nostall", 32'(stall_d), 0);
    chk("t1_cycle1", cycle_count, 32'(exp_cycles));
    tick();
    drive(1, 0, 0, 0, 9, 0, 0);
    chk("t1_fwd_s2", 32'(fwd_s_sel), 2);
    tick();
    chk("t1_fwd_s0", 32'(fwd_s_sel), 0);
    chk("t1_retire1", retire_count, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t1_retire3", retire_count, 3);

    // Load r4 followed by rt=r4: one stall cycle, then forward from slot 2.
    drive(1, 4, 1, 0, 0, 0, 0);
    chk("t2_stall0", 32'(stall_d), 0);
    tick();
    drive(1, 5, 0, 0, 0, 4, 0);
    chk("t2_stall1", 32'(stall_d), 1);
    chk("t2_scnt0", stall_count, 0);
    tick();
    chk("t2_stall_clr", 32'(stall_d), 0);
    chk("t2_fwd_t2", 32'(fwd_t_sel), 2);
    chk("t2_scnt1", stall_count, 1);
    chk("t2_retire3", retire_count, 3);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t2_retire5", retire_count, 5);

    // Two writers of r7 in flight: the younger (slot 1) wins.
    drive(1, 7, 0, 0, 0, 0, 0);
    tick();
    drive(1, 7, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 7, 0, 0);
    chk("t3_fwd_young", 32'(fwd_s_sel), 1);
    chk("t3_nostall", 32'(stall_d), 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("t3_r0_fwd_s", 32'(fwd_s_sel), 0);
    chk("t3_r0_fwd_t", 32'(fwd_t_sel), 0);
    chk("t3_r0_stall", 32'(stall_d), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t3_retire9", retire_count, 9);

    // Redirect during a load-use hazard: flush, no stall, decode discarded.
    drive(1, 3, 1, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 3, 1);
    chk("t4_flush", 32'(flush_fd), 1);
    chk("t4_stall_supp", 32'(stall_d), 0);
    chk("t4_fcnt0", flush_count, 0);
    tick();
    drive(1, 0, 0, 0, 1, 3, 0);
    chk("t4_flush_clr", 32'(flush_fd), 0);
    chk("t4_fcnt1", flush_count, 1);
    chk("t4_bubble", 32'(fwd_s_sel), 0);
    chk("t4_fwd_t2", 32'(fwd_t_sel), 2);
    chk("t4_stall0", 32'(stall_d), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t4_retire11", retire_count, 11);
    chk("t4_scnt1", stall_count, 1);

    // Three instructions then halt; drain, halt three cycles after accept.
    drive(1, 11, 0, 0, 0, 0, 0);
    tick();
    drive(1, 12, 0, 0, 0, 0, 0);
    tick();
    drive(1, 13, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("t5_stall_run", 32'(stall_d), 0);
    chk("t5_halted0", 32'(halted), 0);
    tick();
    drive(1, 14, 0, 0, 0, 0, 0);
    chk("t5_stall_drain", 32'(stall_d), 1);
    chk("t5_halted_a", 32'(halted), 0);
    tick();
    chk("t5_halted_b", 32'(halted), 0);
    tick();
    chk("t5_halted_c", 32'(halted), 0);
    chk("t5_retire15", retire_count, 15);
    tick();
    chk("t5_halted1", 32'(halted), 1);
    exp_halted = 1'b1;
    chk("t5_cycle", cycle_count, 32'(exp_cycles));
    chk("t5_scnt_drain", stall_count, 1);
    repeat (10) tick();
    chk("t5_cycle_frozen", cycle_count, 32'(exp_cycles));
    chk("t5_retire_frozen", retire_count, 15);
    chk("t5_halted_hold", 32'(halted), 1);
    chk("t5_stall_halted", 32'(stall_d), 0);
    chk("sat_cycle", 32'(cycle_count_s), 7);
    chk("sat_retire", 32'(retire_count_s), 7);
    chk("sat_stall", 32'(stall_count_s), 1);
    chk("sat_flush", 32'(flush_count_s), 1);
    chk("sat_halted", 32'(halted_s), 1);

    // Leave HALTED by reset, enter DRAIN, then reset asynchronously mid-drain.
    cpu_resetn = 1'b0;
    #1;
    chk("t6_halt_rst", 32'(halted), 0);
    chk("t6_cycle_rst", cycle_count, 0);
    cpu_resetn = 1'b1;
    exp_halted = 1'b0;
    exp_cycles = 0;
    drive(1, 0, 0, 1, 0, 0, 0);
    tick();
    drive(1, 6, 0, 0, 0, 0, 0);
    chk("t6_drain_stall", 32'(stall_d), 1);
    cpu_resetn = 1'b0;
    #1;
    chk("t6_async_stall", 32'(stall_d), 0);
    chk("t6_async_halted", 32'(halted), 0);
    chk("t6_async_cycle", cycle_count, 0);
    chk("t6_async_retire", retire_count, 0);
    chk("t6_async_fwd", 32'(fwd_s_sel), 0);
    cpu_resetn = 1'b1;
    exp_cycles = 0;
    #1;
    chk("t6_run_stall", 32'(stall_d), 0);
    tick();
    drive(1, 0, 0, 0, 6, 0, 0);
    chk("t6_fresh_fwd", 32'(fwd_s_sel), 1);
    chk("t6_fresh_stall", 32'(stall_d), 0);
    chk("t6_cycle1", cycle_count, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t6_retire1", retire_count, 1);
    chk("t6_cycle3", cycle_count, 32'(exp_cycles));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
